lenet_seq: RTL and testbench
============================

LENET_SEQ -- requirements
Module: lenet_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the max cycles per layer before timeout (must be >= 2).
REQ-002 The block SHALL have parameter FRAME_CNT_WIDTH, default 16, giving the completed-frame counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: host request to run one frame.
REQ-007 The block SHALL have port abort, input, 1 bit: host cancel of the frame in progress.
REQ-008 The block SHALL have port err_clear, input, 1 bit: host acknowledge that leaves ERR.
REQ-009 The block SHALL have port conv_done, input, 1 bit: conv layer finished.
REQ-010 The block SHALL have port fc1_done, input, 1 bit: FC1 finished.
REQ-011 The block SHALL have port fc2_done, input, 1 bit: FC2 finished.
REQ-012 The block SHALL have port conv_start, output, 1 bit: one-cycle pulse that launches conv.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a frame is in flight.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-015 The block SHALL have port error, output, 1 bit: sticky error flag.
REQ-016 The block SHALL have port err_code, output, 2 bits: 0 none, 1 protocol, 2 timeout.
REQ-017 The block SHALL have port state, output, 3 bits: current state, for debug.
REQ-018 The block SHALL have port frame_cnt, output, FRAME_CNT_WIDTH bits: number of completed frames.

Function
REQ-019 The FSM SHALL have states IDLE=0, CONV=1, FC1=2, FC2=3, DONE=4, ERR=5; all outputs are registered.
REQ-020 In IDLE, start=1 at edge N SHALL enter CONV and drive conv_start=1 for exactly cycle N+1.
REQ-021 In CONV, conv_done=1 SHALL move to FC1 on the next edge; in FC1, fc1_done=1 -> FC2; in FC2, fc2_done=1 -> DONE.
REQ-022 DONE SHALL last one cycle with done=1, increment frame_cnt (wrapping at 2^FRAME_CNT_WIDTH to 0), then return to IDLE.
REQ-023 busy SHALL be 1 exactly in CONV, FC1 and FC2.
REQ-024 start outside IDLE SHALL be ignored, with no queueing.
REQ-025 Protocol error: fc1_done or fc2_done high in CONV, or fc2_done high in FC1, SHALL enter ERR with err_code=1; this check takes priority over the legal transition on the same cycle.
REQ-026 A done input that stays high from the previous layer (e.g. conv_done held during FC1) SHALL NOT be an error.
REQ-027 Done inputs sampled in IDLE, DONE or ERR SHALL be ignored.
REQ-028 abort=1 in CONV, FC1 or FC2 SHALL return to IDLE on the next edge, with no done pulse and frame_cnt unchanged.
REQ-029 abort SHALL take priority over all other transitions except reset.
REQ-030 In ERR, error SHALL be 1 and err_code held; err_clear=1 SHALL go to IDLE and clear error and err_code.
REQ-031 start SHALL be ignored in ERR.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, conv_start=0, busy=0, done=0, error=0, err_code=0, state=0, frame_cnt=0 and timeout counter=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no done pulse; the first start accepted after rst falls SHALL behave per REQ-020.

Configuration
REQ-034 With macro LENET_SEQ_TIMEOUT_EN defined, the block SHALL keep a per-state cycle counter, cleared on every state entry, that increments in CONV, FC1 and FC2.
REQ-035 With LENET_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without the expected done, the block SHALL enter ERR with err_code=2; a done and a timeout on the same cycle resolve to the done.
REQ-036 With LENET_SEQ_TIMEOUT_EN undefined, the block SHALL have no counter logic and never produce err_code=2.

Verification
REQ-037 Nominal: start@0; conv_done@10, fc1_done@20, fc2_done@30 (pulses) -> conv_start@1 only, busy 1..30, done@31, frame_cnt=1, IDLE@32.
REQ-038 Protocol: start, then fc2_done pulse during CONV -> ERR next cycle, error=1, err_code=1; err_clear -> IDLE, error=0.
REQ-039 Abort and ignore: start, abort during FC1 -> IDLE next cycle, no done, frame_cnt unchanged; start during FC2 of the next frame -> ignored, still one conv_start.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=8): start, no conv_done -> ERR with err_code=2 after 8 cycles in CONV; macro off -> stays in CONV indefinitely.
REQ-041 Wrap and reset: FRAME_CNT_WIDTH=2, 4 frames -> frame_cnt returns to 0; rst asserted mid-FC1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/lenet_seq.sv
// Frame sequencer for a three-layer LeNet engine: launches conv, tracks FC1/FC2
// completion, flags protocol errors. Optional per-layer timeout via LENET_SEQ_TIMEOUT_EN.
module lenet_seq #(
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       err_clear,
    input  logic                       conv_done,
    input  logic                       fc1_done,
    input  logic                       fc2_done,
    output logic                       conv_start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [2:0]                 state,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV   = 3'd1,
        FC1    = 3'd2,
        FC2    = 3'd3,
        DONE_S = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t cur;
    logic   in_layer;
    logic   proto_err;
    logic   layer_done;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("lenet_seq: TIMEOUT_CYCLES must be >= 2");
    end

    assign state = cur;

    assign in_layer   = (cur == CONV) || (cur == FC1) || (cur == FC2);
    // A done from an earlier layer may still be high; only a done from a later layer is illegal.
    assign proto_err  = ((cur == CONV) && (fc1_done || fc2_done)) ||
                        ((cur == FC1)  && fc2_done);
    assign layer_done = ((cur == CONV) && conv_done) ||
                        ((cur == FC1)  && fc1_done)  ||
                        ((cur == FC2)  && fc2_done);

`ifdef LENET_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = in_layer && (tmo_cnt == CNT_MAX);

    // Counter restarts whenever the FSM leaves its current layer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (in_layer && !(abort || proto_err || layer_done || tmo_hit)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'd0;
            frame_cnt  <= '0;
        end else begin
            conv_start <= 1'b0;
            done       <= 1'b0;
            case (cur)
                IDLE: begin
                    if (start) begin
                        cur        <= CONV;
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                CONV, FC1, FC2: begin
                    // Priority: abort, protocol error, legal done, timeout.
                    if (abort) begin
                        cur  <= IDLE;
                        busy <= 1'b0;
                    end else if (proto_err) begin
                        cur      <= ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (layer_done) begin
                        case (cur)
                            CONV:    cur <= FC1;
                            FC1:     cur <= FC2;
                            default: begin
                                cur       <= DONE_S;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
                            end
                        endcase
                    end else if (tmo_hit) begin
                        cur      <= ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= 2'd2;
                    end
                end
                DONE_S: begin
                    cur <= IDLE;
                end
                ERR: begin
                    if (err_clear) begin
                        cur      <= IDLE;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                    end
                end
                default: begin
                    cur      <= IDLE;
                    busy     <= 1'b0;
                    error    <= 1'b0;
                    err_code <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_seq.sv
// Directed bench for lenet_seq with TIMEOUT_CYCLES=8 and FRAME_CNT_WIDTH=2.
module tb_lenet_seq;

    localparam int TO = 8;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst, start, abort, err_clear, conv_done, fc1_done, fc2_done;
    logic          conv_start, busy, done, error;
    logic [1:0]    err_code;
    logic [2:0]    state;
    logic [FW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses;
    int busy_low;

    lenet_seq #(.TIMEOUT_CYCLES(TO), .FRAME_CNT_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .err_clear(err_clear),
        .conv_done(conv_done), .fc1_done(fc1_done), .fc2_done(fc2_done),
        .conv_start(conv_start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .state(state), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pulses   += int'(conv_start);
        busy_low += int'(!busy);
    endtask

    task automatic run_frame();
        start = 1'b1;     tick(); start = 1'b0;
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        fc1_done = 1'b1;  tick(); fc1_done = 1'b0;
        fc2_done = 1'b1;  tick(); fc2_done = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; err_clear = 1'b0;
        conv_done = 1'b0; fc1_done = 1'b0; fc2_done = 1'b0;
        pulses = 0; busy_low = 0;
        #12;
        chk("reset_outs", {conv_start, busy, done, error, err_code, state, frame_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_rst", {29'd0, state}, 32'd0);

        // Nominal frame: start@0, conv_done@10, fc1_done@20, fc2_done@30
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nom_conv_state", {29'd0, state}, 32'd1);
        chk("nom_conv_start", {31'd0, conv_start}, 32'd1);
        pulses = 1; busy_low = 0;
        repeat (9) tick();
        chk("nom_conv_start_once", pulses, 1);
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        chk("nom_fc1_state", {29'd0, state}, 32'd2);
        repeat (9) tick();
        fc1_done = 1'b1; tick(); fc1_done = 1'b0;
        chk("nom_fc2_state", {29'd0, state}, 32'd3);
        repeat (9) tick();
        chk("nom_busy_1_to_30", busy_low, 0);
        fc2_done = 1'b1; tick(); fc2_done = 1'b0;
        chk("nom_done_state", {29'd0, state}, 32'd4);
        chk("nom_done_pulse", {30'd0, done, busy}, 32'b10);
        chk("nom_frame_cnt", {30'd0, frame_cnt}, 32'd1);
        chk("nom_total_pulses", pulses, 1);
        tick();
        chk("nom_back_idle", {29'd0, state, done}, 32'd0);

        // Protocol error: fc2_done while in CONV
        start = 1'b1; tick(); start = 1'b0;
        fc2_done = 1'b1; tick(); fc2_done = 1'b0;
        chk("proto_err_state", {29'd0, state}, 32'd5);
        chk("proto_err_flags", {28'd0, error, err_code, busy}, 32'b0_01_0 | 32'b1_00_0);
        start = 1'b1; tick(); start = 1'b0;
        chk("err_ignores_start", {27'd0, state, err_code}, {27'd0, 3'd5, 2'd1});
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("err_clear", {28'd0, state, error}, 32'd0);
        chk("err_clear_code", {30'd0, err_code}, 32'd0);

        // Held conv_done in FC1 is legal; fc1+fc2 together in FC1 is an error
        start = 1'b1; tick(); start = 1'b0;
        conv_done = 1'b1; tick();
        tick();
        chk("held_conv_done_ok", {29'd0, state}, 32'd2);
        conv_done = 1'b0; fc1_done = 1'b1; fc2_done = 1'b1;
        tick();
        fc1_done = 1'b0; fc2_done = 1'b0;
        chk("proto_over_legal", {27'd0, state, err_code}, {27'd0, 3'd5, 2'd1});
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // Abort during FC1
        start = 1'b1; tick(); start = 1'b0;
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", {29'd0, state}, 32'd0);
        chk("abort_no_done", {30'd0, done, busy}, 32'd0);
        chk("abort_cnt_kept", {30'd0, frame_cnt}, 32'd1);

        // Start during FC2 is ignored
        start = 1'b1; tick(); start = 1'b0;
        pulses = int'(conv_start);
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        fc1_done = 1'b1;  tick(); fc1_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_fc2_ignored", {29'd0, state}, 32'd3);
        fc2_done = 1'b1; tick(); fc2_done = 1'b0;
        chk("second_frame_done", {29'd0, done, frame_cnt}, {29'd0, 1'b1, 2'd2});
        chk("second_frame_one_pulse", pulses, 1);
        tick();

        // Abort beats a legal done on the same cycle
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; conv_done = 1'b1; tick(); abort = 1'b0; conv_done = 1'b0;
        chk("abort_priority", {29'd0, state}, 32'd0);

        // Timeout behaviour
        start = 1'b1; tick(); start = 1'b0;
`ifdef LENET_SEQ_TIMEOUT_EN
        repeat (TO - 1) tick();
        chk("tmo_still_conv", {29'd0, state}, 32'd1);
        tick();
        chk("tmo_err", {26'd0, state, error, err_code}, {26'd0, 3'd5, 1'b1, 2'd2});
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (TO - 1) tick();
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        chk("done_beats_tmo", {27'd0, state, err_code}, {27'd0, 3'd2, 2'd0});
`else
        repeat (30) tick();
        chk("no_tmo_stays_conv", {28'd0, state, busy}, {28'd0, 3'd1, 1'b1});
        chk("no_tmo_code", {30'd0, err_code}, 32'd0);
`endif
        abort = 1'b1; tick(); abort = 1'b0;
        chk("tmo_abort_idle", {29'd0, state}, 32'd0);

        // Frame counter wrap at 2 bits
        run_frame();
        chk("cnt_3", {30'd0, frame_cnt}, 32'd3);
        run_frame();
        chk("cnt_wrap_0", {30'd0, frame_cnt}, 32'd0);

        // Asynchronous reset mid-FC1
        start = 1'b1; tick(); start = 1'b0;
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        run_frame_check_fc1: chk("pre_rst_fc1", {29'd0, state}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {conv_start, busy, done, error, err_code, state, frame_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {29'd0, state, done}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("post_rst_start", {28'd0, state, conv_start}, {28'd0, 3'd1, 1'b1});
        abort = 1'b1; tick(); abort = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
